// File: rtl/custom_rptr_empty.sv
// Read-side pointer, empty / almost-empty flags and fill level for a dual-clock FIFO.
// Optional sticky underflow flag is enabled by defining RPTR_UNDERFLOW_FLAG_EN.
module custom_rptr_empty #(
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk_i,
    input  logic                rrst_i,
    input  logic                ren,
    input  logic [ADDRSIZE:0]   wptr_sync2_rdclk,
    output logic [ADDRSIZE-1:0] rd_addr,
    output logic [ADDRSIZE:0]   rptr_g,
    output logic                fifo_empty,
    output logic                fifo_almost_empty,
    output logic [ADDRSIZE:0]   rd_level
`ifdef RPTR_UNDERFLOW_FLAG_EN
    ,
    input  logic                underflow_clr,
    output logic                fifo_underflow
`endif
);

    // Handshake: a read is accepted at the rising edge where ren=1 and
    // fifo_empty=0; rd_addr names the entry consumed by that edge. ren while
    // fifo_empty=1 is not accepted and changes no pointer state.

    logic [ADDRSIZE:0] rbin_reg;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] wbin_sync;
    logic [ADDRSIZE:0] lvl;
    logic              rinc;
    logic              empty_next;
    logic              almost_next;

    // Gray-to-binary of the synchronized write pointer, MSB down.
    always_comb begin
        wbin_sync           = '0;
        wbin_sync[ADDRSIZE] = wptr_sync2_rdclk[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            wbin_sync[i] = wbin_sync[i+1] ^ wptr_sync2_rdclk[i];
        end
    end

    always_comb begin
        rinc        = ren & ~fifo_empty;
        rbin_next   = rbin_reg + {{ADDRSIZE{1'b0}}, rinc};
        rgray_next  = (rbin_next >> 1) ^ rbin_next;
        // Full-width Gray equality keeps empty exact across the address wrap.
        empty_next  = (rgray_next == wptr_sync2_rdclk);
        lvl         = wbin_sync - rbin_next;
        almost_next = empty_next | (lvl == (ADDRSIZE+1)'(1));
    end

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            rbin_reg          <= '0;
            rptr_g            <= '0;
            rd_level          <= '0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
        end else begin
            rbin_reg          <= rbin_next;
            rptr_g            <= rgray_next;
            rd_level          <= lvl;
            fifo_empty        <= empty_next;
            fifo_almost_empty <= almost_next;
        end
    end

    assign rd_addr = rbin_reg[ADDRSIZE-1:0];

`ifdef RPTR_UNDERFLOW_FLAG_EN
    // Sticky; a new underflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            fifo_underflow <= 1'b0;
        end else if (ren & fifo_empty) begin
            fifo_underflow <= 1'b1;
        end else if (underflow_clr) begin
            fifo_underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_custom_rptr_empty.sv
// Directed bench for custom_rptr_empty (ADDRSIZE=4); expected values are hand-derived.
module tb_custom_rptr_empty;

    localparam int AW = 4;

    logic          rclk_i;
    logic          rrst_i;
    logic          ren;
    logic [AW:0]   wptr_sync2_rdclk;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rptr_g;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [AW:0]   rd_level;
`ifdef RPTR_UNDERFLOW_FLAG_EN
    logic          underflow_clr;
    logic          fifo_underflow;
`endif

    int err_cnt;
    int chk_cnt;
    logic [31:0] exp_q[$];

    custom_rptr_empty #(.ADDRSIZE(AW)) dut (
        .rclk_i            (rclk_i),
        .rrst_i            (rrst_i),
        .ren               (ren),
        .wptr_sync2_rdclk  (wptr_sync2_rdclk),
        .rd_addr           (rd_addr),
        .rptr_g            (rptr_g),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .rd_level          (rd_level)
`ifdef RPTR_UNDERFLOW_FLAG_EN
        ,
        .underflow_clr     (underflow_clr),
        .fifo_underflow    (fifo_underflow)
`endif
    );

    // clock / reset
    initial rclk_i = 1'b0;
    always #5 rclk_i = ~rclk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // drive before calling; returns 1 time unit after the edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rclk_i);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  32'(rd_addr), 32'd0);
        check({tag, "_rptr"},  32'(rptr_g), 32'd0);
        check({tag, "_empty"}, 32'(fifo_empty), 32'd1);
        check({tag, "_almost"}, 32'(fifo_almost_empty), 32'd1);
        check({tag, "_level"}, 32'(rd_level), 32'd0);
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rrst_i  = 1'b1;
        ren     = 1'b1;
        wptr_sync2_rdclk = 5'b00101;
`ifdef RPTR_UNDERFLOW_FLAG_EN
        underflow_clr = 1'b0;
`endif

        // 1 reset overrides ren and write pointer
        tick(2);
        check_reset_values("rst");

        // 2 fill to 3 then drain
        rrst_i = 1'b0;
        ren    = 1'b0;
        wptr_sync2_rdclk = 5'b00010;
        tick(1);
        check("fill_empty",  32'(fifo_empty), 32'd0);
        check("fill_almost", 32'(fifo_almost_empty), 32'd0);
        check("fill_level",  32'(rd_level), 32'd3);
        check("fill_addr",   32'(rd_addr), 32'd0);
        ren = 1'b1;
        tick(1);
        check("drain1_addr",   32'(rd_addr), 32'd1);
        check("drain1_level",  32'(rd_level), 32'd2);
        check("drain1_almost", 32'(fifo_almost_empty), 32'd0);
        tick(1);
        check("drain2_addr",   32'(rd_addr), 32'd2);
        check("drain2_level",  32'(rd_level), 32'd1);
        check("drain2_almost", 32'(fifo_almost_empty), 32'd1);
        check("drain2_empty",  32'(fifo_empty), 32'd0);
        tick(1);
        check("drain3_addr",  32'(rd_addr), 32'd3);
        check("drain3_level", 32'(rd_level), 32'd0);
        check("drain3_empty", 32'(fifo_empty), 32'd1);
        tick(1);
        check("drain4_addr", 32'(rd_addr), 32'd3);
        check("drain4_rptr", 32'(rptr_g), 32'b00010);

        // 3 reads while empty leave the pointers alone
        tick(5);
        check("under_addr",  32'(rd_addr), 32'd3);
        check("under_rptr",  32'(rptr_g), 32'b00010);
        check("under_empty", 32'(fifo_empty), 32'd1);
        check("under_level", 32'(rd_level), 32'd0);
`ifdef RPTR_UNDERFLOW_FLAG_EN
        check("under_flag", 32'(fifo_underflow), 32'd1);
        ren = 1'b0;
        tick(2);
        check("under_sticky", 32'(fifo_underflow), 32'd1);
        underflow_clr = 1'b1;
        tick(1);
        check("under_clr", 32'(fifo_underflow), 32'd0);
        ren = 1'b1;
        tick(1);
        check("under_set_wins", 32'(fifo_underflow), 32'd1);
        ren = 1'b0;
        tick(1);
        check("under_clr2", 32'(fifo_underflow), 32'd0);
        underflow_clr = 1'b0;
`endif

        // 4 full FIFO and wrap
        rrst_i = 1'b1;
        ren    = 1'b0;
        wptr_sync2_rdclk = 5'b11000;
        tick(1);
        check_reset_values("rst2");
        rrst_i = 1'b0;
        tick(1);
        check("full_level", 32'(rd_level), 32'd16);
        check("full_empty", 32'(fifo_empty), 32'd0);
        check("full_almost", 32'(fifo_almost_empty), 32'd0);
        for (int k = 1; k <= 16; k++) exp_q.push_back(32'(k % 16));
        ren = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            check("wrap_addr", 32'(rd_addr), exp_q.pop_front());
            check("wrap_level", 32'(rd_level), 32'(16 - k));
        end
        check("wrap_rptr",  32'(rptr_g), 32'b11000);
        check("wrap_empty", 32'(fifo_empty), 32'd1);

        // 5 read and write in the same cycle at level 1
        ren = 1'b0;
        wptr_sync2_rdclk = 5'b11001;
        tick(1);
        check("conc0_level",  32'(rd_level), 32'd1);
        check("conc0_almost", 32'(fifo_almost_empty), 32'd1);
        ren = 1'b1;
        wptr_sync2_rdclk = 5'b11011;
        tick(1);
        check("conc_level",  32'(rd_level), 32'd1);
        check("conc_empty",  32'(fifo_empty), 32'd0);
        check("conc_almost", 32'(fifo_almost_empty), 32'd1);
        check("conc_addr",   32'(rd_addr), 32'd1);
        check("conc_rptr",   32'(rptr_g), 32'b11001);

        // 6 reset in the middle of a stream
        rrst_i = 1'b1;
        ren    = 1'b0;
        wptr_sync2_rdclk = 5'b00000;
        tick(1);
        rrst_i = 1'b0;
        wptr_sync2_rdclk = 5'b01100;
        tick(1);
        check("mid_fill_level", 32'(rd_level), 32'd8);
        ren = 1'b1;
        tick(3);
        check("mid_level", 32'(rd_level), 32'd5);
        check("mid_addr",  32'(rd_addr), 32'd3);
        rrst_i = 1'b1;
        tick(1);
        check_reset_values("mid_rst");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
